// File: rtl/bus_drvr_pkg.sv
// Shared constants and helpers for the bus driver endpoint.
// Provides ID field width, broadcast ID, counter width and ID extraction.
package bus_drvr_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  localparam int CNT_W = 16;
  localparam int WORD_MAX = 64;

  // Top ID_W bits of a w_bits-wide word (word zero-extended to WORD_MAX).
  function automatic logic [ID_W-1:0] id_field(
    input logic [WORD_MAX-1:0] w,
    input int unsigned w_bits
  );
    return ID_W'(w >> (w_bits - ID_W));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with sync active-high reset.
// Ports: clk, reset, wr_en/din, rd_en/dout, full, empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic wr_ok, rd_ok;

  // Extra pointer MSB tells full from empty.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // Writes and reads are judged on pre-edge full/empty.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign wr_d = wr_ok ? wr_q + 1'b1 : wr_q;
  assign rd_d = rd_ok ? rd_q + 1'b1 : rd_q;

  assign dout = mem[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bus_drvr_endpoint.sv
// Driver-side arbiter endpoint: TX FIFO toward pndng/pop/D_pop, RX FIFO
// from push/D_push with ID filter, drop and overflow saturating counters.
module bus_drvr_endpoint
  import bus_drvr_pkg::*;
#(
  parameter int bits = 32,
  parameter int depth = 8,
  parameter logic [ID_W-1:0] id = 8'h00,
  parameter logic [ID_W-1:0] broadcast = BCAST_ID
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [bits-1:0]  tx_data,
  output logic             pndng,
  input  logic             pop,
  output logic [bits-1:0]  D_pop,
  input  logic             push,
  input  logic [bits-1:0]  D_push,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [bits-1:0]  rx_data,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] ovfl_cnt
);

  logic tx_full, tx_empty;
  logic rx_full, rx_empty;
  logic [ID_W-1:0] push_id;
  logic hit;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] ovfl_q, ovfl_d;

  sync_fifo #(
    .WIDTH(bits),
    .DEPTH(depth)
  ) u_tx (
    .clk  (clk),
    .reset(reset),
    .wr_en(tx_valid),
    .din  (tx_data),
    .rd_en(pop),
    .dout (D_pop),
    .full (tx_full),
    .empty(tx_empty)
  );

  assign tx_ready = !tx_full;
  assign pndng    = !tx_empty;

  assign push_id = id_field(WORD_MAX'(D_push), bits);
  assign hit = push &&
               (push_id == id || push_id == broadcast);

  sync_fifo #(
    .WIDTH(bits),
    .DEPTH(depth)
  ) u_rx (
    .clk  (clk),
    .reset(reset),
    .wr_en(hit),
    .din  (D_push),
    .rd_en(rx_ready),
    .dout (rx_data),
    .full (rx_full),
    .empty(rx_empty)
  );

  assign rx_valid = !rx_empty;

  always_comb begin
    drop_d = drop_q;
    ovfl_d = ovfl_q;
    if (push && !hit) drop_d = sat_inc(drop_q);
    if (hit && rx_full) ovfl_d = sat_inc(ovfl_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
      ovfl_q <= '0;
    end else begin
      drop_q <= drop_d;
      ovfl_q <= ovfl_d;
    end
  end

  assign drop_cnt = drop_q;
  assign ovfl_cnt = ovfl_q;

endmodule

// File: tb/tb_bus_drvr_endpoint.sv
// Testbench for bus_drvr_endpoint (bits=32, depth=4, id=8'h02).
// Directed vector table, hand sequences and randomized model checks.
module tb_bus_drvr_endpoint;

  logic clk = 1'b0;
  logic reset;
  logic tx_valid, tx_ready;
  logic [31:0] tx_data;
  logic pndng, pop;
  logic [31:0] D_pop;
  logic push;
  logic [31:0] D_push;
  logic rx_valid, rx_ready;
  logic [31:0] rx_data;
  logic [15:0] drop_cnt, ovfl_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_drvr_endpoint #(
    .bits(32),
    .depth(4),
    .id(8'h02),
    .broadcast(8'hFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .pndng   (pndng),
    .pop     (pop),
    .D_pop   (D_pop),
    .push    (push),
    .D_push  (D_push),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_data (rx_data),
    .drop_cnt(drop_cnt),
    .ovfl_cnt(ovfl_cnt)
  );

  // Reference model: plain queues and integer counters.
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  int m_drop, m_ovfl;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    txq.delete();
    rxq.delete();
    m_drop = 0;
    m_ovfl = 0;
  endtask

  task automatic model_step();
    bit tx_w, tx_r, rx_w, rx_r;
    logic [7:0] pid;
    tx_w = tx_valid && (txq.size() < 4);
    tx_r = pop && (txq.size() > 0);
    rx_r = rx_ready && (rxq.size() > 0);
    rx_w = 1'b0;
    pid = D_push[31:24];
    if (push) begin
      if (pid == 8'h02 || pid == 8'hFF) begin
        if (rxq.size() < 4) rx_w = 1'b1;
        else if (m_ovfl < 65535) m_ovfl++;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end
    if (tx_r) void'(txq.pop_front());
    if (tx_w) txq.push_back(tx_data);
    if (rx_r) void'(rxq.pop_front());
    if (rx_w) rxq.push_back(D_push);
  endtask

  task automatic mcheck();
    chk("m_pndng", 32'(pndng), 32'(txq.size() > 0));
    chk("m_tx_ready", 32'(tx_ready), 32'(txq.size() < 4));
    if (txq.size() > 0) chk("m_D_pop", D_pop, txq[0]);
    chk("m_rx_valid", 32'(rx_valid), 32'(rxq.size() > 0));
    if (rxq.size() > 0) chk("m_rx_data", rx_data, rxq[0]);
    chk("m_drop", 32'(drop_cnt), 32'(m_drop));
    chk("m_ovfl", 32'(ovfl_cnt), 32'(m_ovfl));
  endtask

  task automatic cyc(input logic tv, input logic [31:0] td,
                     input logic pp, input logic ps,
                     input logic [31:0] dp, input logic rr);
    tx_valid = tv;
    tx_data  = td;
    pop      = pp;
    push     = ps;
    D_push   = dp;
    rx_ready = rr;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tx_valid = 0; pop = 0; push = 0; rx_ready = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic tv;
    logic [31:0] td;
    logic pp;
    logic ps;
    logic [31:0] dp;
    logic rr;
    logic e_pnd;
    logic e_txr;
    logic [31:0] e_dpop;
    logic e_rxv;
    logic [31:0] e_rxd;
    int e_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic tv, logic [31:0] td, logic pp, logic ps,
    logic [31:0] dp, logic rr, logic e_pnd, logic e_txr,
    logic [31:0] e_dpop, logic e_rxv, logic [31:0] e_rxd,
    int e_drop);
    vec_t v;
    v.tv = tv; v.td = td; v.pp = pp; v.ps = ps;
    v.dp = dp; v.rr = rr; v.e_pnd = e_pnd; v.e_txr = e_txr;
    v.e_dpop = e_dpop; v.e_rxv = e_rxv; v.e_rxd = e_rxd;
    v.e_drop = e_drop;
    return v;
  endfunction

  initial begin
    tx_valid = 0; tx_data = 0; pop = 0;
    push = 0; D_push = 0; rx_ready = 0;
    reset = 1'b1;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_pndng", 32'(pndng), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_ovfl", 32'(ovfl_cnt), 0);
    reset = 1'b0;

    //         tv td            pp ps dp            rr pnd txr dpop          rxv rxd           drop
    vecs.push_back(mk(0, 0,            0, 0, 0,            0, 0, 1, 0,            0, 0,            0));
    vecs.push_back(mk(1, 32'h02000001, 0, 0, 0,            0, 1, 1, 32'h02000001, 0, 0,            0));
    vecs.push_back(mk(1, 32'h02000002, 0, 0, 0,            0, 1, 1, 32'h02000001, 0, 0,            0));
    vecs.push_back(mk(1, 32'h02000003, 0, 0, 0,            0, 1, 1, 32'h02000001, 0, 0,            0));
    vecs.push_back(mk(1, 32'h02000004, 0, 0, 0,            0, 1, 0, 32'h02000001, 0, 0,            0));
    vecs.push_back(mk(1, 32'h02000005, 0, 0, 0,            0, 1, 0, 32'h02000001, 0, 0,            0));
    vecs.push_back(mk(0, 0,            1, 0, 0,            0, 1, 1, 32'h02000002, 0, 0,            0));
    vecs.push_back(mk(0, 0,            1, 0, 0,            0, 1, 1, 32'h02000003, 0, 0,            0));
    vecs.push_back(mk(0, 0,            1, 0, 0,            0, 1, 1, 32'h02000004, 0, 0,            0));
    vecs.push_back(mk(0, 0,            1, 0, 0,            0, 0, 1, 0,            0, 0,            0));
    vecs.push_back(mk(0, 0,            1, 0, 0,            0, 0, 1, 0,            0, 0,            0));
    vecs.push_back(mk(1, 32'h02000010, 0, 0, 0,            0, 1, 1, 32'h02000010, 0, 0,            0));
    vecs.push_back(mk(1, 32'h02000011, 1, 0, 0,            0, 1, 1, 32'h02000011, 0, 0,            0));
    vecs.push_back(mk(0, 0,            1, 0, 0,            0, 0, 1, 0,            0, 0,            0));
    vecs.push_back(mk(0, 0,            0, 1, 32'h020000AA, 0, 0, 1, 0,            1, 32'h020000AA, 0));
    vecs.push_back(mk(0, 0,            0, 1, 32'hFF0000BB, 0, 0, 1, 0,            1, 32'h020000AA, 0));
    vecs.push_back(mk(0, 0,            0, 1, 32'h050000CC, 0, 0, 1, 0,            1, 32'h020000AA, 1));
    vecs.push_back(mk(0, 0,            0, 0, 0,            1, 0, 1, 0,            1, 32'hFF0000BB, 1));
    vecs.push_back(mk(0, 0,            0, 0, 0,            1, 0, 1, 0,            0, 0,            1));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].tv, vecs[i].td, vecs[i].pp, vecs[i].ps,
          vecs[i].dp, vecs[i].rr);
      chk($sformatf("v%0d_pndng", i), 32'(pndng), 32'(vecs[i].e_pnd));
      chk($sformatf("v%0d_tx_ready", i), 32'(tx_ready),
          32'(vecs[i].e_txr));
      if (vecs[i].e_pnd)
        chk($sformatf("v%0d_D_pop", i), D_pop, vecs[i].e_dpop);
      chk($sformatf("v%0d_rx_valid", i), 32'(rx_valid),
          32'(vecs[i].e_rxv));
      if (vecs[i].e_rxv)
        chk($sformatf("v%0d_rx_data", i), rx_data, vecs[i].e_rxd);
      chk($sformatf("v%0d_drop", i), 32'(drop_cnt),
          32'(vecs[i].e_drop));
      chk($sformatf("v%0d_ovfl", i), 32'(ovfl_cnt), 0);
    end

    // RX overflow: five accepted words into a 4-deep FIFO.
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, 1, 32'h02000100 + 32'(i), 0);
    chk("ovf_cnt1", 32'(ovfl_cnt), 1);
    chk("ovf_head", rx_data, 32'h02000100);
    // Full FIFO: same-cycle read must not make room for the push.
    cyc(0, 0, 0, 1, 32'h02000105, 1);
    chk("ovf_cnt2", 32'(ovfl_cnt), 2);
    for (int i = 1; i < 4; i++) begin
      chk("ovf_valid", 32'(rx_valid), 1);
      chk($sformatf("ovf_drain%0d", i), rx_data, 32'h02000100 + 32'(i));
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("ovf_empty", 32'(rx_valid), 0);
    chk("ovf_drop", 32'(drop_cnt), 1);

    // Reset with three words buffered in each FIFO.
    for (int i = 0; i < 3; i++)
      cyc(1, 32'h02000200 + 32'(i), 0, 1, 32'h02000300 + 32'(i), 0);
    chk("pre_rst_pndng", 32'(pndng), 1);
    chk("pre_rst_rxv", 32'(rx_valid), 1);
    reset = 1'b1;
    tx_valid = 0; push = 0;
    @(posedge clk);
    #1;
    chk("mid_rst_pndng", 32'(pndng), 0);
    chk("mid_rst_rxv", 32'(rx_valid), 0);
    chk("mid_rst_txr", 32'(tx_ready), 1);
    chk("mid_rst_drop", 32'(drop_cnt), 0);
    chk("mid_rst_ovfl", 32'(ovfl_cnt), 0);
    reset = 1'b0;
    model_clear();
    cyc(0, 0, 1, 0, 0, 1);
    mcheck();

    // Randomized traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] pid;
      logic [31:0] w;
      case ($urandom_range(0, 3))
        0: pid = 8'h02;
        1: pid = 8'hFF;
        2: pid = 8'h05;
        default: pid = 8'($urandom);
      endcase
      w = {pid, 24'($urandom)};
      cyc(1'($urandom_range(0, 2) != 0), $urandom,
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)), w,
          1'($urandom_range(0, 3) == 0));
      mcheck();
    end

    // Drop counter saturation.
    do_reset();
    for (int n = 0; n < 65537; n++)
      cyc(0, 0, 0, 1, 32'h07000000, 0);
    chk("sat_drop", 32'(drop_cnt), 32'hFFFF);
    cyc(0, 0, 0, 1, 32'h07000000, 0);
    chk("sat_hold", 32'(drop_cnt), 32'hFFFF);
    mcheck();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
